// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, stop-bit tick count and
// the transmit-FIFO controller state encoding.
package uart_pkg;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array, DBIT x 2**ADDR_W, no reset.
// Ports: clk, we_i/waddr_i/wdata_i sync write, raddr_i -> rdata_o async read.
module uart_fifo_mem #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DBIT-1:0]   wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DBIT-1:0]   rdata_o
);

    logic [DBIT-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit front-end: FIFO plus launch controller.
// Ports: clk, reset_n, clr, wr_en/wr_data in; full/empty/count/overflow
// status; tx_busy, tx_start, tx_din to the transmitter; tx_done_tick back.
module uart_tx_fifo #(
    parameter int DBIT   = uart_pkg::DBIT,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [DBIT-1:0] wr_data,
    output logic            full,
    output logic            empty,
    output logic [ADDR_W:0] count,
    output logic            overflow,
    output logic            tx_busy,
    output logic            tx_start,
    output logic [DBIT-1:0] tx_din,
    input  logic            tx_done_tick
);

    import uart_pkg::*;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(2**ADDR_W);

    tx_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              start_q, start_d;
    logic [DBIT-1:0]   din_q, din_d;
    logic [DBIT-1:0]   head;
    logic              wr_acc;
    logic              pop;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign count    = cnt_q;
    assign overflow = ovf_q;
    assign tx_busy  = (state_q == LAUNCH) || (state_q == BUSY);
    assign tx_start = start_q;
    assign tx_din   = din_q;

    // clr wins over both the write and the pop
    assign wr_acc = wr_en && !full && !clr;
    assign pop    = (state_q == IDLE) && !empty && !clr;

    uart_fifo_mem #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (wr_data),
        .raddr_i (rptr_q),
        .rdata_o (head)
    );

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + ADDR_W'(1);
            end
            if (wr_en && full) begin
                ovf_d = 1'b1;
            end
            unique case ({wr_acc, pop})
                2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // the FSM ignores clr once a byte is launched
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = LAUNCH;
                    start_d = 1'b1;
                    din_d   = head;
                end
            end
            LAUNCH: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (tx_done_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            start_q <= start_d;
            din_q   <= din_d;
        end
    end

endmodule
